// File: rtl/multicycle_control_if.sv
// ============================================================================
// Module   : multicycle_control_if
// Brief    : Opcode/flag inputs and datapath control outputs of the MIPS
//            multi-cycle controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multicycle_control_if;
  logic [5:0] OP;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic [2:0] ALUOp;
  logic [3:0] state;
  logic       timeout_err;
  logic       illegal_op;

  modport master (
    input  OP, zero, mem_ready,
    output PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
           RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, state,
           timeout_err, illegal_op
  );

  modport slave (
    output OP, zero, mem_ready,
    input  PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
           RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, state,
           timeout_err, illegal_op
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// Module   : multicycle_control
// Brief    : Moore-style multi-cycle MIPS control FSM with memory-ready
//            handshake, optional wait timeout and sticky error flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control #(
  parameter int USE_MEM_READY = 1,
  parameter int WAIT_TIMEOUT  = 0
) (
  input  wire                   clk,
  input  wire                   reset,
  multicycle_control_if.master  bus
);

  localparam int c_CNT_W = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
  localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(WAIT_TIMEOUT);

  localparam logic [5:0] c_OP_R    = 6'h00;
  localparam logic [5:0] c_OP_J    = 6'h02;
  localparam logic [5:0] c_OP_BEQ  = 6'h04;
  localparam logic [5:0] c_OP_BNE  = 6'h05;
  localparam logic [5:0] c_OP_ADDI = 6'h08;
  localparam logic [5:0] c_OP_ORI  = 6'h0d;
  localparam logic [5:0] c_OP_LUI  = 6'h0f;
  localparam logic [5:0] c_OP_LW   = 6'h23;
  localparam logic [5:0] c_OP_SW   = 6'h2b;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEMADDR  = 4'd3,
    MEMREAD  = 4'd4,
    MEMWB    = 4'd5,
    MEMWRITE = 4'd6,
    RTYPE_EX = 4'd7,
    RTYPE_WB = 4'd8,
    BRANCH   = 4'd9,
    IMM_EX   = 4'd10,
    IMM_WB   = 4'd11,
    JUMP     = 4'd12
  } state_t;

  typedef struct packed {
    logic       pcWrite;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       regDst;
    logic       memtoReg;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] pcSource;
    logic [2:0] aluOp;
  } ctrl_t;

  state_t               r_state;
  logic [5:0]           r_opQ;
  logic [c_CNT_W-1:0]   r_waitCnt;
  logic                 r_timeoutErr;
  logic                 r_illegalOp;
  ctrl_t                r_ctrl;

  state_t               w_next;
  logic [5:0]           w_opNext;
  logic                 w_illegal;
  logic                 w_ready;
  logic                 w_waitState;
  logic                 w_timeout;
  logic                 w_taken;
  logic [c_CNT_W-1:0]   w_cntInc;

  // State-only part of the output decode; the ready/zero qualified strobes
  // are added combinationally below.
  function automatic ctrl_t decodeState(input state_t s, input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.memRead = 1'b1;
        c.aluSrcB = 2'b01;
        c.aluOp   = 3'b100;
      end
      DECODE: begin
        c.aluSrcB = 2'b11;
        c.aluOp   = 3'b100;
      end
      MEMADDR: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = 2'b10;
        c.aluOp   = 3'b100;
      end
      MEMREAD: begin
        c.memRead = 1'b1;
        c.iorD    = 1'b1;
      end
      MEMWB: begin
        c.memtoReg = 1'b1;
        c.regWrite = 1'b1;
      end
      MEMWRITE: begin
        c.memWrite = 1'b1;
        c.iorD     = 1'b1;
      end
      RTYPE_EX: begin
        c.aluSrcA = 1'b1;
        c.aluOp   = 3'b111;
      end
      RTYPE_WB: begin
        c.regDst   = 1'b1;
        c.regWrite = 1'b1;
      end
      BRANCH: begin
        c.aluSrcA  = 1'b1;
        c.aluOp    = 3'b001;
        c.pcSource = 2'b01;
      end
      IMM_EX: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = 2'b10;
        case (op)
          c_OP_ORI: c.aluOp = 3'b101;
          c_OP_LUI: c.aluOp = 3'b110;
          default:  c.aluOp = 3'b100;
        endcase
      end
      IMM_WB: c.regWrite = 1'b1;
      JUMP: begin
        c.pcWrite  = 1'b1;
        c.pcSource = 2'b10;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  assign w_ready     = (USE_MEM_READY != 0) ? bus.mem_ready : 1'b1;
  assign w_waitState = (r_state == FETCH) || (r_state == MEMREAD) || (r_state == MEMWRITE);
  assign w_cntInc    = r_waitCnt + c_CNT_W'(1);
  // Count includes the current not-ready cycle, so the abort lands on the
  // edge that ends the WAIT_TIMEOUT-th waiting cycle.
  assign w_timeout   = (WAIT_TIMEOUT > 0) && w_waitState && !w_ready && (w_cntInc == c_TIMEOUT);
  assign w_taken     = ((r_opQ == c_OP_BEQ) && bus.zero) || ((r_opQ == c_OP_BNE) && !bus.zero);

  always_comb begin
    w_next    = r_state;
    w_opNext  = r_opQ;
    w_illegal = 1'b0;
    case (r_state)
      IDLE:  w_next = FETCH;
      FETCH: if (w_ready) w_next = DECODE;
      DECODE: begin
        w_opNext = bus.OP;
        case (bus.OP)
          c_OP_LW, c_OP_SW:               w_next = MEMADDR;
          c_OP_R:                         w_next = RTYPE_EX;
          c_OP_BEQ, c_OP_BNE:             w_next = BRANCH;
          c_OP_ADDI, c_OP_ORI, c_OP_LUI:  w_next = IMM_EX;
          c_OP_J:                         w_next = JUMP;
          default: begin
            w_next    = FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      MEMADDR: begin
        if (r_opQ == c_OP_SW)
          w_next = MEMWRITE;
        else if (r_opQ == c_OP_LW)
          w_next = MEMREAD;
        else
          w_next = FETCH;
      end
      MEMREAD:  if (w_ready) w_next = MEMWB;
      MEMWB:    w_next = FETCH;
      MEMWRITE: if (w_ready) w_next = FETCH;
      RTYPE_EX: w_next = RTYPE_WB;
      RTYPE_WB: w_next = FETCH;
      BRANCH:   w_next = FETCH;
      IMM_EX:   w_next = IMM_WB;
      IMM_WB:   w_next = FETCH;
      JUMP:     w_next = FETCH;
      default:  w_next = FETCH;
    endcase
    if (w_timeout)
      w_next = FETCH;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_opQ        <= 6'd0;
      r_waitCnt    <= '0;
      r_timeoutErr <= 1'b0;
      r_illegalOp  <= 1'b0;
      r_ctrl       <= '0;
    end else begin
      r_state <= w_next;
      r_opQ   <= w_opNext;
      r_ctrl  <= decodeState(w_next, w_opNext);
      // A timeout from FETCH re-enters FETCH, so it must clear the count too.
      if ((w_next != r_state) || w_timeout)
        r_waitCnt <= '0;
      else if (w_waitState && !w_ready)
        r_waitCnt <= w_cntInc;
      if (w_timeout)
        r_timeoutErr <= 1'b1;
      if (w_illegal)
        r_illegalOp <= 1'b1;
    end
  end

  assign bus.PCWrite     = r_ctrl.pcWrite
                         | ((r_state == FETCH) & w_ready)
                         | ((r_state == BRANCH) & w_taken);
  assign bus.IRWrite     = (r_state == FETCH) & w_ready;
  assign bus.IorD        = r_ctrl.iorD;
  assign bus.MemRead     = r_ctrl.memRead;
  assign bus.MemWrite    = r_ctrl.memWrite;
  assign bus.RegDst      = r_ctrl.regDst;
  assign bus.MemtoReg    = r_ctrl.memtoReg;
  assign bus.RegWrite    = r_ctrl.regWrite;
  assign bus.ALUSrcA     = r_ctrl.aluSrcA;
  assign bus.ALUSrcB     = r_ctrl.aluSrcB;
  assign bus.PCSource    = r_ctrl.pcSource;
  assign bus.ALUOp       = r_ctrl.aluOp;
  assign bus.state       = r_state;
  assign bus.timeout_err = r_timeoutErr;
  assign bus.illegal_op  = r_illegalOp;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// Module   : tb_multicycle_control
// Brief    : Directed scoreboard bench for multicycle_control (handshake and
//            no-handshake builds side by side).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_if busA ();
  multicycle_control_if busB ();

  assign busB.OP        = busA.OP;
  assign busB.zero      = busA.zero;
  assign busB.mem_ready = 1'b0;

  multicycle_control #(.USE_MEM_READY(1), .WAIT_TIMEOUT(5)) dutA (
    .clk   (clk),
    .reset (reset),
    .bus   (busA.master)
  );

  multicycle_control #(.USE_MEM_READY(0), .WAIT_TIMEOUT(0)) dutB (
    .clk   (clk),
    .reset (reset),
    .bus   (busB.master)
  );

  wire [21:0] obsA = {busA.state, busA.PCWrite, busA.IorD, busA.MemRead, busA.MemWrite,
                      busA.IRWrite, busA.RegDst, busA.MemtoReg, busA.RegWrite, busA.ALUSrcA,
                      busA.ALUSrcB, busA.PCSource, busA.ALUOp, busA.timeout_err, busA.illegal_op};
  wire [21:0] obsB = {busB.state, busB.PCWrite, busB.IorD, busB.MemRead, busB.MemWrite,
                      busB.IRWrite, busB.RegDst, busB.MemtoReg, busB.RegWrite, busB.ALUSrcA,
                      busB.ALUSrcB, busB.PCSource, busB.ALUOp, busB.timeout_err, busB.illegal_op};

  typedef struct {
    string       tag;
    bit          selB;
    logic [21:0] v;
  } exp_t;

  exp_t       sbq[$];
  int         nCmp = 0;
  int         nErr = 0;
  logic [5:0] mOp  = 6'h00;
  logic       mTe  = 1'b0;
  logic       mIl  = 1'b0;

  // Expected output vector of one state, taken straight from the state table.
  function automatic logic [21:0] model(input logic [3:0] st, input logic [5:0] op,
                                        input logic z, input logic rdy,
                                        input logic te, input logic il);
    logic pcw, iord, mr, mw, irw, rd, m2r, rw, asa;
    logic [1:0] asb, pcs;
    logic [2:0] aop;
    {pcw, iord, mr, mw, irw, rd, m2r, rw, asa} = '0;
    asb = 2'b00; pcs = 2'b00; aop = 3'b000;
    case (st)
      4'd1:  begin mr = 1; asb = 2'b01; aop = 3'b100; irw = rdy; pcw = rdy; end
      4'd2:  begin asb = 2'b11; aop = 3'b100; end
      4'd3:  begin asa = 1; asb = 2'b10; aop = 3'b100; end
      4'd4:  begin mr = 1; iord = 1; end
      4'd5:  begin m2r = 1; rw = 1; end
      4'd6:  begin mw = 1; iord = 1; end
      4'd7:  begin asa = 1; aop = 3'b111; end
      4'd8:  begin rd = 1; rw = 1; end
      4'd9:  begin
        asa = 1; aop = 3'b001; pcs = 2'b01;
        pcw = ((op == 6'h04) && z) || ((op == 6'h05) && !z);
      end
      4'd10: begin
        asa = 1; asb = 2'b10;
        aop = (op == 6'h0d) ? 3'b101 : (op == 6'h0f) ? 3'b110 : 3'b100;
      end
      4'd11: rw = 1;
      4'd12: begin pcw = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {st, pcw, iord, mr, mw, irw, rd, m2r, rw, asa, asb, pcs, aop, te, il};
  endfunction

  task automatic expA(input string tag, input logic [3:0] st, input logic rdy);
    exp_t e;
    e.tag = tag; e.selB = 1'b0;
    e.v = model(st, mOp, busA.zero, rdy, mTe, mIl);
    sbq.push_back(e);
  endtask

  task automatic expBoth(input string tag, input logic [3:0] st);
    exp_t e;
    expA(tag, st, 1'b1);
    e.tag = {tag, "_nohs"}; e.selB = 1'b1;
    e.v = model(st, mOp, busA.zero, 1'b1, 1'b0, 1'b0);
    sbq.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    logic [21:0] obs;
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      obs = e.selB ? obsB : obsA;
      nCmp++;
      assert (obs === e.v) else begin
        nErr++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    check();
    tick();
  endtask

  initial begin
    reset          = 1'b0;
    busA.OP        = 6'h23;
    busA.zero      = 1'b0;
    busA.mem_ready = 1'b1;
    tick();
    expBoth("reset", 4'd0);              check();
    reset = 1'b1;
    expBoth("idle", 4'd0);               cyc();

    // LW on both builds; the no-handshake build has mem_ready tied low.
    mOp = 6'h23;
    expBoth("lw_fetch", 4'd1);           cyc();
    expBoth("lw_decode", 4'd2);          cyc();
    expBoth("lw_memaddr", 4'd3);         cyc();
    expBoth("lw_memread", 4'd4);         cyc();
    expBoth("lw_memwb", 4'd5);           cyc();

    busA.OP = 6'h04; busA.zero = 1'b1; mOp = 6'h04;
    expA("beq_fetch", 4'd1, 1'b1);       cyc();
    expA("beq_decode", 4'd2, 1'b1);      cyc();
    expA("beq_branch", 4'd9, 1'b1);      cyc();

    busA.OP = 6'h05; mOp = 6'h05;
    expA("bne_fetch", 4'd1, 1'b1);       cyc();
    expA("bne_decode", 4'd2, 1'b1);      cyc();
    expA("bne_branch", 4'd9, 1'b1);      cyc();

    busA.OP = 6'h00; mOp = 6'h00; busA.mem_ready = 1'b0;
    expA("r_wait1", 4'd1, 1'b0);         cyc();
    expA("r_wait2", 4'd1, 1'b0);         cyc();
    expA("r_wait3", 4'd1, 1'b0);         cyc();
    busA.mem_ready = 1'b1;
    expA("r_fetch", 4'd1, 1'b1);         cyc();
    expA("r_decode", 4'd2, 1'b1);        cyc();
    expA("r_ex", 4'd7, 1'b1);            cyc();
    expA("r_wb", 4'd8, 1'b1);            cyc();

    busA.OP = 6'h0d; mOp = 6'h0d;
    expA("ori_fetch", 4'd1, 1'b1);       cyc();
    expA("ori_decode", 4'd2, 1'b1);      cyc();
    expA("ori_ex", 4'd10, 1'b1);         cyc();
    expA("ori_wb", 4'd11, 1'b1);         cyc();

    busA.OP = 6'h0f; mOp = 6'h0f;
    expA("lui_fetch", 4'd1, 1'b1);       cyc();
    expA("lui_decode", 4'd2, 1'b1);      cyc();
    expA("lui_ex", 4'd10, 1'b1);         cyc();
    expA("lui_wb", 4'd11, 1'b1);         cyc();

    // SW with memory never ready: five waiting cycles, then abort.
    busA.OP = 6'h2b; mOp = 6'h2b;
    expA("sw_fetch", 4'd1, 1'b1);        cyc();
    expA("sw_decode", 4'd2, 1'b1);       cyc();
    expA("sw_memaddr", 4'd3, 1'b1);      cyc();
    busA.mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expA("sw_wait", 4'd6, 1'b0);       cyc();
    end
    busA.mem_ready = 1'b1; mTe = 1'b1;

    busA.OP = 6'h02; mOp = 6'h02;
    expA("to_fetch", 4'd1, 1'b1);        cyc();
    expA("j_decode", 4'd2, 1'b1);        cyc();
    expA("j_jump", 4'd12, 1'b1);         cyc();

    busA.OP = 6'h3f; mOp = 6'h3f;
    expA("ill_fetch", 4'd1, 1'b1);       cyc();
    expA("ill_decode", 4'd2, 1'b1);      cyc();
    mIl = 1'b1;

    busA.OP = 6'h23; mOp = 6'h23;
    expA("ill_next", 4'd1, 1'b1);        cyc();
    expA("lw2_decode", 4'd2, 1'b1);      cyc();
    expA("lw2_memaddr", 4'd3, 1'b1);     cyc();
    expA("lw2_memread", 4'd4, 1'b1);     check();
    reset = 1'b0; mTe = 1'b0; mIl = 1'b0;
    expA("rst_mid", 4'd0, 1'b1);         check();
    tick();
    expA("rst_hold", 4'd0, 1'b1);        check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule

`default_nettype wire
